// File: rtl/pipeline_hazard_unit_if.sv
// Datapath <-> hazard unit bundle: the decoding instruction plus branch outcome in,
// pipeline control and EX operand selects out.
interface pipeline_hazard_unit_if #(
   parameter int unsigned REG_AW = 5
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic [REG_AW-1:0] id_dst;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              branch_taken;

   logic              stall;
   logic              bubble_ex;
   logic              flush_if_id;
   logic              freeze;
   logic [1:0]        forward_a;
   logic [1:0]        forward_b;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_dst, id_reg_write, id_mem_read, branch_taken,
      input  stall, bubble_ex, flush_if_id, freeze, forward_a, forward_b
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_dst, id_reg_write, id_mem_read, branch_taken,
      output stall, bubble_ex, flush_if_id, freeze, forward_a, forward_b
   );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: shadows EX/MEM/WB
// destination fields and produces stall, bubble, flush, freeze and forward selects.
module pipeline_hazard_unit #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MEM_LAT = 1,
   parameter bit          FWD_EN  = 1'b1
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_unit_if.slave hz
);

   localparam int unsigned      CNT_W    = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   logic              ex_v, ex_use_rs, ex_use_rt, ex_rw, ex_mr;
   logic [REG_AW-1:0] ex_rs, ex_rt, ex_dst;
   logic              mem_v, mem_rw, mem_mr;
   logic [REG_AW-1:0] mem_dst;
   logic              wb_v, wb_rw;
   logic [REG_AW-1:0] wb_dst;
   logic [CNT_W-1:0]  cnt;

   logic frozen;
   logic bubble;
   logic ex_hit, mem_hit;
   logic load_use, raw_any, hazard;
   logic mem_fwd_ok, wb_fwd_ok;

   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic              use_src,
      input logic              m_ok,
      input logic [REG_AW-1:0] m_dst,
      input logic              w_ok,
      input logic [REG_AW-1:0] w_dst
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (use_src && m_ok && m_dst != '0 && m_dst == src)
         sel = 2'b10;
      else if (use_src && w_ok && w_dst != '0 && w_dst == src)
         sel = 2'b01;
      return sel;
   endfunction

   assign frozen = (cnt != '0);

   // Valid bits and the memory counter are the only state that needs reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_v  <= 1'b0;
         mem_v <= 1'b0;
         wb_v  <= 1'b0;
         cnt   <= '0;
      end else if (frozen) begin
         cnt <= cnt - 1'b1;
      end else begin
         wb_v  <= mem_v;
         mem_v <= ex_v;
         ex_v  <= hz.id_valid & ~bubble;
         if (ex_v && ex_mr)
            cnt <= CNT_LOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (!frozen) begin
         wb_dst    <= mem_dst;
         wb_rw     <= mem_rw;
         mem_dst   <= ex_dst;
         mem_rw    <= ex_rw;
         mem_mr    <= ex_mr;
         ex_rs     <= hz.id_rs;
         ex_rt     <= hz.id_rt;
         ex_use_rs <= hz.id_use_rs;
         ex_use_rt <= hz.id_use_rt;
         ex_dst    <= hz.id_dst;
         ex_rw     <= hz.id_reg_write;
         ex_mr     <= hz.id_mem_read;
      end
   end

   always_comb begin
      ex_hit  = (ex_dst != '0) &&
                ((hz.id_use_rs && hz.id_rs == ex_dst) || (hz.id_use_rt && hz.id_rt == ex_dst));
      mem_hit = (mem_dst != '0) &&
                ((hz.id_use_rs && hz.id_rs == mem_dst) || (hz.id_use_rt && hz.id_rt == mem_dst));
      load_use = ex_v & ex_mr & ex_hit;
      // Without forwarding any in-flight producer in EX or MEM blocks the reader.
      raw_any  = (ex_v & ex_rw & ex_hit) | (mem_v & mem_rw & mem_hit);
      hazard   = FWD_EN ? load_use : raw_any;
   end

   always_comb begin
      hz.stall       = 1'b0;
      hz.flush_if_id = 1'b0;
      hz.freeze      = 1'b0;
      bubble         = 1'b0;
      if (frozen) begin
         hz.freeze = 1'b1;
         hz.stall  = 1'b1;
      end else if (hz.branch_taken) begin
         hz.flush_if_id = 1'b1;
         bubble         = 1'b1;
      end else if (hazard) begin
         hz.stall = 1'b1;
         bubble   = 1'b1;
      end
      hz.bubble_ex = bubble;
   end

   always_comb begin
      mem_fwd_ok   = mem_v & mem_rw & ~mem_mr;
      wb_fwd_ok    = wb_v & wb_rw;
      hz.forward_a = 2'b00;
      hz.forward_b = 2'b00;
      if (FWD_EN) begin
         hz.forward_a = fwd_sel(ex_rs, ex_use_rs, mem_fwd_ok, mem_dst, wb_fwd_ok, wb_dst);
         hz.forward_b = fwd_sel(ex_rt, ex_use_rt, mem_fwd_ok, mem_dst, wb_fwd_ok, wb_dst);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench: three configurations share one instruction stream; a pipeline-queue
// reference model predicts each cycle's controls and a negedge monitor compares.
module tb_pipeline_hazard_unit;

   typedef struct {
      bit v;
      int rs;
      int rt;
      bit urs;
      bit urt;
      int dst;
      bit rw;
      bit mr;
   } instr_t;

   localparam int NCFG = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   instr_t id_in;
   bit     br_in;
   bit     rst_in;

   pipeline_hazard_unit_if #(.REG_AW(5)) bus [NCFG] ();
   logic [7:0] dut_o [NCFG];

   for (genvar g = 0; g < NCFG; g++) begin : g_dut
      always_comb begin
         bus[g].id_valid     = id_in.v;
         bus[g].id_rs        = 5'(id_in.rs);
         bus[g].id_rt        = 5'(id_in.rt);
         bus[g].id_use_rs    = id_in.urs;
         bus[g].id_use_rt    = id_in.urt;
         bus[g].id_dst       = 5'(id_in.dst);
         bus[g].id_reg_write = id_in.rw;
         bus[g].id_mem_read  = id_in.mr;
         bus[g].branch_taken = br_in;
         dut_o[g] = {bus[g].stall, bus[g].bubble_ex, bus[g].flush_if_id, bus[g].freeze,
                     bus[g].forward_a, bus[g].forward_b};
      end

      pipeline_hazard_unit #(
         .REG_AW (5),
         .MEM_LAT((g == 1) ? 3 : 1),
         .FWD_EN ((g == 2) ? 1'b0 : 1'b1)
      ) u_dut (
         .clk(clk),
         .rst(rst_in),
         .hz (bus[g])
      );
   end

   // Reference model: pipe[k][0..2] = instructions in EX, MEM, WB; mem_busy = frozen cycles left.
   int     lat [NCFG] = '{1, 3, 1};
   bit     fwd [NCFG] = '{1'b1, 1'b1, 1'b0};
   instr_t pipe [NCFG][3];
   int     mem_busy [NCFG];

   logic [7:0] exp_q [NCFG][$];
   int n_cmp = 0;
   int n_bad = 0;

   function automatic bit id_reads(int r);
      return r != 0 && ((id_in.urs && id_in.rs == r) || (id_in.urt && id_in.rt == r));
   endfunction

   function automatic int operand_src(int k, int r, bit used);
      instr_t m = pipe[k][1];
      instr_t w = pipe[k][2];
      if (!fwd[k] || !used || r == 0) return 0;
      if (m.v && m.rw && !m.mr && m.dst == r) return 2;
      if (w.v && w.rw && w.dst == r) return 1;
      return 0;
   endfunction

   function automatic logic [7:0] predict(int k);
      instr_t e = pipe[k][0];
      instr_t m = pipe[k][1];
      bit hz_stall;
      bit st = 0, bb = 0, fl = 0, fz = 0;
      int fa, fb;
      if (fwd[k])
         hz_stall = e.v && e.mr && id_reads(e.dst);
      else
         hz_stall = (e.v && e.rw && id_reads(e.dst)) || (m.v && m.rw && id_reads(m.dst));
      if (mem_busy[k] > 0) begin
         fz = 1; st = 1;
      end else if (br_in) begin
         fl = 1; bb = 1;
      end else if (hz_stall) begin
         st = 1; bb = 1;
      end
      fa = operand_src(k, e.rs, e.urs);
      fb = operand_src(k, e.rt, e.urt);
      return {st, bb, fl, fz, 2'(fa), 2'(fb)};
   endfunction

   function automatic void advance(int k, bit bubbled);
      instr_t nop = '{default: 0};
      if (rst_in) begin
         for (int s = 0; s < 3; s++) pipe[k][s] = nop;
         mem_busy[k] = 0;
      end else if (mem_busy[k] > 0) begin
         mem_busy[k]--;
      end else begin
         if (pipe[k][0].v && pipe[k][0].mr) mem_busy[k] = lat[k] - 1;
         pipe[k][2] = pipe[k][1];
         pipe[k][1] = pipe[k][0];
         pipe[k][0] = id_in;
         pipe[k][0].v = id_in.v && !bubbled;
      end
   endfunction

   task automatic cycle(input instr_t s, input bit br, input bit r);
      logic [7:0] o;
      @(posedge clk);
      for (int k = 0; k < NCFG; k++) begin
         o = predict(k);
         advance(k, o[6]);
      end
      #1;
      id_in  = s;
      br_in  = br;
      rst_in = r;
      for (int k = 0; k < NCFG; k++) exp_q[k].push_back(predict(k));
   endtask

   function automatic instr_t mk(bit v, int rs, int rt, bit urs, bit urt, int dst, bit rw, bit mr);
      instr_t i;
      i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
      i.dst = dst; i.rw = rw; i.mr = mr;
      return i;
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < NCFG; k++) begin
         if (exp_q[k].size() > 0) begin
            logic [7:0] want;
            want = exp_q[k].pop_front();
            n_cmp++;
            if (dut_o[k] !== want) begin
               n_bad++;
               $display("FAIL ctl_cfg%0d t=%0t: got %b want %b (stall,bubble,flush,freeze,fa,fb)",
                        k, $time, dut_o[k], want);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t nop;
      instr_t r;
      nop    = mk(0, 0, 0, 0, 0, 0, 0, 0);
      id_in  = nop;
      br_in  = 0;
      rst_in = 1;
      for (int k = 0; k < NCFG; k++) begin
         for (int s = 0; s < 3; s++) pipe[k][s] = nop;
         mem_busy[k] = 0;
      end
      cycle(nop, 0, 1);
      cycle(nop, 0, 0);

      // add $3,$1,$2 ; sub $4,$3,$5 ; then with one independent instruction between
      cycle(mk(1, 1, 2, 1, 1, 3, 1, 0), 0, 0);
      cycle(mk(1, 3, 5, 1, 1, 4, 1, 0), 0, 0);
      repeat (4) cycle(nop, 0, 0);
      cycle(mk(1, 1, 2, 1, 1, 3, 1, 0), 0, 0);
      cycle(mk(1, 7, 7, 1, 1, 6, 1, 0), 0, 0);
      cycle(mk(1, 3, 5, 1, 1, 4, 1, 0), 0, 0);
      repeat (4) cycle(nop, 0, 0);
      // lw $2,0($1) ; add $4,$2,$2 (re-presented while stalled)
      cycle(mk(1, 1, 0, 1, 0, 2, 1, 1), 0, 0);
      repeat (2) cycle(mk(1, 2, 2, 1, 1, 4, 1, 0), 0, 0);
      repeat (5) cycle(nop, 0, 0);
      // add $0,... ; reader of $0
      cycle(mk(1, 1, 2, 1, 1, 0, 1, 0), 0, 0);
      cycle(mk(1, 0, 0, 1, 1, 5, 1, 0), 0, 0);
      repeat (4) cycle(nop, 0, 0);
      // lw then nops, reset during the second frozen cycle
      cycle(mk(1, 1, 0, 1, 0, 2, 1, 1), 0, 0);
      cycle(nop, 0, 0);
      cycle(nop, 0, 0);
      cycle(nop, 0, 1);
      repeat (3) cycle(nop, 0, 0);
      // load-use hazard coinciding with a taken branch
      cycle(mk(1, 1, 0, 1, 0, 2, 1, 1), 0, 0);
      cycle(mk(1, 2, 2, 1, 1, 4, 1, 0), 1, 0);
      repeat (5) cycle(nop, 0, 0);
      // add $3 followed by an immediate reader of $3
      cycle(mk(1, 1, 2, 1, 1, 3, 1, 0), 0, 0);
      repeat (3) cycle(mk(1, 3, 3, 1, 1, 4, 1, 0), 0, 0);
      repeat (5) cycle(nop, 0, 0);

      for (int n = 0; n < 3000; n++) begin
         r.v   = ($urandom_range(7) != 0);
         r.rs  = $urandom_range(3);
         r.rt  = $urandom_range(3);
         r.urs = $urandom_range(3) != 0;
         r.urt = $urandom_range(1);
         r.dst = $urandom_range(3);
         r.rw  = $urandom_range(3) != 0;
         r.mr  = r.rw && ($urandom_range(2) == 0);
         cycle(r, $urandom_range(7) == 0, $urandom_range(99) == 0);
      end

      repeat (2) @(negedge clk);
      for (int k = 0; k < NCFG; k++) begin
         if (exp_q[k].size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_cfg%0d: %0d left, want 0", k, exp_q[k].size());
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised hazard-and-forwarding controller for the 5-stage MIPS pipeline; successor to the stand-alone forwarding unit.
- Keeps its own shadow copy of the EX, MEM and WB stage destination fields, so the datapath only presents the decoding instruction each cycle.
- Adds four functions:
  - load-use stall;
  - taken-branch flush;
  - multi-cycle data-memory freeze;
  - a no-forwarding mode that resolves every hazard by stalling.

Parameters:
REG_AW, 5, register-address width; register 0 is hard-wired zero.
MEM_LAT, 1, cycles a load occupies MEM (≥1); MEM_LAT=1 means a single-cycle memory.
FWD_EN, 1, 1 = forwarding enabled; 0 = forward outputs fixed at 00 and RAW hazards resolved by stalling.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID/EX register holds a real instruction (not a bubble)
id_rs, id_rt  in  REG_AW  source registers of the ID instruction
id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
id_dst  in  REG_AW  destination after RegDst mux
id_reg_write  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
branch_taken  in  1  branch resolved taken in EX this cycle
stall  out  1  hold PC and IF/ID
bubble_ex  out  1  load NOP into ID/EX next edge
flush_if_id  out  1  clear IF/ID next edge
freeze  out  1  hold ID/EX, EX/MEM, MEM/WB (memory wait)
forward_a, forward_b  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB

Behaviour:
Shadow pipeline:
- Registers: ex_{v,rs,rt,use_rs,use_rt,dst,rw,mr}, mem_{v,dst,rw,mr}, wb_{v,dst,rw}.
- On each edge with freeze=0:
  - MEM→WB and EX→MEM copy unconditionally.
  - ID→EX copies id_*, with ex_v = id_valid & ~bubble_ex.
- freeze=1: all shadows hold.

Reset:
- All *_v = 0; memory counter = 0.
- Outputs therefore read stall=0, bubble_ex=0, flush_if_id=0, freeze=0, forward_a=forward_b=00 in the cycle after rst.
- rst mid-freeze or mid-stall aborts it immediately.

Forwarding (FWD_EN=1), combinational from shadows; shown for forward_a, the same for forward_b with rt:
- 10 if mem_v & mem_rw & ~mem_mr & mem_dst≠0 & mem_dst==ex_rs & ex_use_rs.
- else 01 if wb_v & wb_rw & wb_dst≠0 & wb_dst==ex_rs & ex_use_rs.
- else 00.
- EX/MEM has priority over MEM/WB.
- A load in MEM is never forwarded from EX/MEM; the load-use stall guarantees it is consumed from MEM/WB.

Hazard detection:
- The register file is write-before-read, so WB never causes a hazard.
- Load-use (FWD_EN=1): ex_v & ex_mr & ex_dst≠0 & ((id_use_rs & ex_dst==id_rs) | (id_use_rt & ex_dst==id_rt)).
- RAW without forwarding (FWD_EN=0): the same compare against the EX stage (ex_rw, any opcode) OR the MEM stage (mem_rw). Stall persists until the producer reaches WB.
- On a hazard: stall=1, bubble_ex=1.

Memory freeze:
- Counter cnt, width clog2(MEM_LAT+1).
- When a load enters MEM (edge with freeze=0 and ex_v & ex_mr), cnt ← MEM_LAT−1.
- freeze = (cnt≠0); stall = 1 whenever freeze = 1.
- cnt decrements each freezing cycle. The load leaves MEM on the edge where cnt is already 0.
- MEM_LAT=1: freeze is never asserted.

Priority, highest first:
1. rst
2. freeze
3. branch_taken
4. hazard stall

- While freeze=1: bubble_ex=0 and flush_if_id=0; branch_taken is ignored (the datapath holds it stable; it is acted on in the first unfrozen cycle).
- branch_taken with freeze=0: flush_if_id=1, bubble_ex=1, stall=0 (PC takes the target). The wrong-path ID instruction is discarded, so no hazard stall is raised that cycle.

Test Plan:
1. add $3,$1,$2 then sub $4,$3,$5 (FWD_EN=1): the cycle sub is in EX → forward_a=10, stall=0. Insert one independent instruction between them → forward_a=01.
2. lw $2,0($1) then add $4,$2,$2: stall=1, bubble_ex=1 for exactly one cycle. Next cycle forward_a=forward_b=01.
3. Writes to $0 (add $0,...) followed by a reader of $0 → forward_a=00, no stall.
4. MEM_LAT=3, lw then nop: freeze=1 and stall=1 for exactly 2 cycles after the lw enters MEM. Shadows hold. Assert rst during the 2nd freeze cycle → next cycle all outputs 0.
5. branch_taken=1 while the ID instruction would raise a load-use hazard: flush_if_id=1, bubble_ex=1, stall=0. Next cycle ex_v=0, so no forwarding from the flushed slot.
6. FWD_EN=0, add $3 followed immediately by a reader of $3: stall=1 for 2 cycles (producer in EX, then MEM). forward_* stay 00 throughout.
